aes_round_ctrl: RTL

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_pkg.sv | 27 ++
 rtl/aes_round_ctrl_rcon_gen.sv | 22 ++
 rtl/aes_round_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants, state encoding and GF(2^8) helper for the AES round controller
package aes_pkg;

    // Number of cipher rounds; the controller is built for AES-128 only.
    localparam int NR = 10;

    // First round constant of the key expansion.
    localparam logic [7:0] RCON_INIT = 8'h01;

    // Width of the round counter presented to the datapath.
    localparam int IDX_W = 4;

    // Controller states: waiting for a block, running rounds, holding the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Multiply by x in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        logic [7:0] shifted;
        shifted = {b[6:0], 1'b0};
        xtime   = b[7] ? (shifted ^ 8'h1b) : shifted;
    endfunction

endpackage

// File: rtl/aes_round_ctrl_rcon_gen.sv
// rtl/aes_round_ctrl_rcon_gen.sv - round constant register advanced by xtime once per round
module rcon_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       step,
    output logic [7:0] rcon
);
    import aes_pkg::*;

    // Reload on init (new block), otherwise multiply by x each time a round completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcon <= RCON_INIT;
        end else if (init) begin
            rcon <= RCON_INIT;
        end else if (step) begin
            rcon <= xtime(rcon);
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - sequencing FSM driving an iterative AES-128 encryption datapath
module aes_round_ctrl #(
    parameter int NR = aes_pkg::NR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic       abort,
    output logic       ld_state,
    output logic       rnd_en,
    output logic       skip_mix,
    output logic [3:0] round_idx,
    output logic [7:0] rcon,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);
    import aes_pkg::*;

    // Round index at which the final (MixColumns-free) round runs.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);

    state_t     state;
    logic [7:0] rcon_q;
    logic       accept;
    logic       last_round;

    // A block is taken only from IDLE, and abort always wins over start.
    assign accept     = (state == IDLE) && start_valid && !abort;
    assign last_round = (state == ROUND) && (round_idx == LAST_IDX);

    // Datapath strobes are decoded from the state register; only ld_state sees the inputs.
    always_comb begin
        ld_state    = accept;
        rnd_en      = (state == ROUND);
        skip_mix    = last_round;
        out_valid   = (state == DONE);
        busy        = (state != IDLE);
        start_ready = (state == IDLE);
        rcon        = (state == ROUND) ? rcon_q : 8'h00;
    end

    // Main sequencer: IDLE -> ROUND (NR cycles, no stalls) -> DONE until handshake or abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            round_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid && !abort) begin
                        state     <= ROUND;
                        round_idx <= IDX_W'(1);
                    end
                end
                ROUND: begin
                    if (abort) begin
                        state     <= IDLE;
                        round_idx <= '0;
                    end else if (round_idx == LAST_IDX) begin
                        state     <= DONE;
                        round_idx <= '0;
                    end else begin
                        round_idx <= round_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    // Abort and a consumer handshake both land in IDLE; no start in this cycle.
                    if (abort || out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    round_idx <= '0;
                end
            endcase
        end
    end

    // Key-expansion constant: restarted for every accepted block, advanced every round.
    rcon_gen u_rcon_gen (
        .clk  (clk),
        .rst  (rst),
        .init (accept),
        .step (rnd_en),
        .rcon (rcon_q)
    );

endmodule
